ice51_uart_loader: RTL and testbench

Serial boot loader for the ice51 core. Receives 8N1 UART bytes on `i_uart_rx` and writes them sequentially into code memory from address 0. Holds the CPU off via `o_load_done` until `MEM_SIZE` bytes have landed. Sits between the top-level `i_uart_rx` pin and the code memory write port in `ice51_top`, and is the receiving end of the host-side byte stream that loads a program image.

---
 rtl/ice51_uart_loader.sv | 195 +++++++++++++++++++
 tb/tb_ice51_uart_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ice51_uart_loader.sv
// ice51_uart_loader: serial boot loader for the ice51 core.
// Receives 8N1 UART bytes and writes them sequentially into code memory
// starting at address 0. o_load_done holds the CPU off until MEM_SIZE bytes
// have been written.
// Build option: ICE51_LOADER_PRELOAD_EN removes the receiver for simulation
// with a preloaded code memory; o_load_done then rises straight out of reset.
module ice51_uart_loader #(
  parameter int CLK_PER_BIT = 104,
  parameter int MEM_SIZE    = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_uart_rx,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_load_done,
  output logic              o_frame_err
);

`ifdef ICE51_LOADER_PRELOAD_EN

  logic done_q;

  // Code memory is already populated, so loading completes on leaving reset.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) done_q <= 1'b0;
    else         done_q <= 1'b1;
  end

  assign o_wr_en     = 1'b0;
  assign o_wr_addr   = '0;
  assign o_wr_data   = '0;
  assign o_frame_err = 1'b0;
  assign o_load_done = done_q;

`else

  localparam int CNT_W = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              rx_meta, rx_s;
  logic [CNT_W-1:0]  clk_cnt_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic [ADDR_W-1:0] wr_cnt_q;
  logic              load_done_q;

  // Control strobes from the FSM to the datapath.
  logic cnt_clr, cnt_inc, bit_clr, bit_inc, shift_en, wr_fire, err_fire;

  // Two-flop synchronizer for the asynchronous pin; idles high out of reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!i_nrst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic and datapath control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    bit_clr  = 1'b0;
    bit_inc  = 1'b0;
    shift_en = 1'b0;
    wr_fire  = 1'b0;
    err_fire = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_clr = 1'b1;
        bit_clr = 1'b1;
        if (!rx_s) state_d = S_START;
      end

      // Re-check the line in the middle of the start bit to reject glitches.
      S_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          cnt_clr = 1'b1;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          bit_inc  = 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      S_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            wr_fire = 1'b1;
            state_d = (wr_cnt_q == ADDR_LAST) ? S_DONE : S_IDLE;
          end else begin
            err_fire = 1'b1;
            state_d  = S_FLUSH;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end

      // A held-low line (break) must return high before a new frame counts.
      S_FLUSH: begin
        if (rx_s) state_d = S_IDLE;
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Bit timing, shift register, write port and completion flag.
  always_ff @(posedge i_clk) begin
    // NOTE: the shift register is reset along with the rest; it is a plain
    // register, not a memory, and the cost is negligible.
    if (!i_nrst) begin
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      wr_cnt_q    <= '0;
      load_done_q <= 1'b0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_frame_err <= 1'b0;
    end else begin
      if (cnt_clr)      clk_cnt_q <= '0;
      else if (cnt_inc) clk_cnt_q <= clk_cnt_q + 1'b1;

      if (bit_clr)      bit_cnt_q <= '0;
      else if (bit_inc) bit_cnt_q <= bit_cnt_q + 1'b1;

      // UART sends LSB first, so new bits enter at the top.
      if (shift_en) shift_q <= {rx_s, shift_q[7:1]};

      o_wr_en     <= wr_fire;
      o_frame_err <= err_fire;

      // Address and data hold their last value between strobes.
      if (wr_fire) begin
        o_wr_addr <= wr_cnt_q;
        o_wr_data <= shift_q;
        wr_cnt_q  <= wr_cnt_q + 1'b1;
      end

      if (state_q == S_DONE) load_done_q <= 1'b1;
    end
  end

  assign o_load_done = load_done_q;

`endif

endmodule

// File: tb/tb_ice51_uart_loader.sv
// Directed testbench for ice51_uart_loader. Uses a short bit period so the
// full 1024-byte image fits in a small cycle budget.
module tb_ice51_uart_loader;

  localparam int CPB   = 4;
  localparam int MSIZE = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          nrst;
  logic          rx;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          load_done;
  logic          frame_err;

  ice51_uart_loader #(
    .CLK_PER_BIT(CPB),
    .MEM_SIZE   (MSIZE),
    .ADDR_W     (AW)
  ) dut (
    .i_clk      (clk),
    .i_nrst     (nrst),
    .i_uart_rx  (rx),
    .o_wr_en    (wr_en),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_load_done(load_done),
    .o_frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t wq[$];
  int  tests = 0;
  int  fails = 0;
  int  err_total = 0;
  int  overlap = 0;
  int  wr_total = 0;
  logic prev_wr = 1'b0;
  logic done_at_wr = 1'b0;
  logic done_after_wr = 1'b0;

  // Observe the write port away from the active edge.
  always @(negedge clk) begin
    if (wr_en) begin
      wq.push_back('{addr: wr_addr, data: wr_data});
      wr_total++;
      done_at_wr = load_done;
    end
    if (frame_err) err_total++;
    if (wr_en && frame_err) overlap++;
    if (prev_wr) done_after_wr = load_done;
    prev_wr = wr_en;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    rx   = 1'b1;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    wq.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v, input int stop_bits);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_v;
    repeat (CPB * stop_bits) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_en"},   32'(wr_en),     32'h0);
    check({tag, "_addr"},    32'(wr_addr),   32'h0);
    check({tag, "_data"},    32'(wr_data),   32'h0);
    check({tag, "_done"},    32'(load_done), 32'h0);
    check({tag, "_ferr"},    32'(frame_err), 32'h0);
  endtask

  initial begin
    int err_before;
    nrst = 1'b0;
    rx   = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    nrst = 1'b1;
    repeat (2) @(negedge clk);

`ifdef ICE51_LOADER_PRELOAD_EN
    check("preload_done", 32'(load_done), 32'h1);
    send_byte(8'hFF, 1'b1, 1);
    repeat (8) @(negedge clk);
    check("preload_no_write", 32'(wr_total), 32'h0);
    check("preload_no_ferr",  32'(err_total), 32'h0);
    check("preload_done_hold", 32'(load_done), 32'h1);
`else
    // Single byte.
    send_byte(8'hA5, 1'b1, 1);
    repeat (4) @(negedge clk);
    check("a5_count", 32'(wq.size()), 32'd1);
    if (wq.size() == 1) begin
      check("a5_addr", 32'(wq[0].addr), 32'h0);
      check("a5_data", 32'(wq[0].data), 32'hA5);
    end
    check("a5_done_after", 32'(done_after_wr), 32'h0);
    check("a5_done", 32'(load_done), 32'h0);

    // Glitch shorter than half a bit, then a real byte.
    do_reset();
    err_before = err_total;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_no_write", 32'(wq.size()), 32'd0);
    check("glitch_no_ferr", 32'(err_total - err_before), 32'd0);
    send_byte(8'h11, 1'b1, 1);
    repeat (4) @(negedge clk);
    check("g11_count", 32'(wq.size()), 32'd1);
    if (wq.size() == 1) begin
      check("g11_addr", 32'(wq[0].addr), 32'h0);
      check("g11_data", 32'(wq[0].data), 32'h11);
    end

    // Framing error: stop bit low for two bit times.
    do_reset();
    err_before = err_total;
    send_byte(8'h5A, 1'b0, 2);
    repeat (4) @(negedge clk);
    check("ferr_pulses", 32'(err_total - err_before), 32'd1);
    check("ferr_no_write", 32'(wq.size()), 32'd0);
    send_byte(8'h77, 1'b1, 1);
    repeat (4) @(negedge clk);
    check("f77_count", 32'(wq.size()), 32'd1);
    if (wq.size() == 1) begin
      check("f77_addr", 32'(wq[0].addr), 32'h0);
      check("f77_data", 32'(wq[0].data), 32'h77);
    end

    // Reset during bit 4 of a frame (data bits 0..3 all ones).
    wq.delete();
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    rx   = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("midrst");
    nrst = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    send_byte(8'h42, 1'b1, 1);
    repeat (4) @(negedge clk);
    check("m42_count", 32'(wq.size()), 32'd1);
    if (wq.size() == 1) begin
      check("m42_addr", 32'(wq[0].addr), 32'h0);
      check("m42_data", 32'(wq[0].data), 32'h42);
    end

    // Full image: data = addr[7:0], back-to-back frames.
    do_reset();
    for (int i = 0; i < MSIZE; i++) begin
      logic [31:0] v;
      v = 32'(i);
      send_byte(v[7:0], 1'b1, 1);
    end
    repeat (4) @(negedge clk);
    check("img_count", 32'(wq.size()), 32'(MSIZE));
    if (wq.size() == MSIZE) begin
      for (int i = 0; i < MSIZE; i++) begin
        logic [31:0] v;
        v = 32'(i);
        check($sformatf("img_addr_%0d", i), 32'(wq[i].addr), 32'(v[AW-1:0]));
        check($sformatf("img_data_%0d", i), 32'(wq[i].data), 32'(v[7:0]));
      end
    end
    check("img_done_at_last_wr", 32'(done_at_wr), 32'h0);
    check("img_done_after_last_wr", 32'(done_after_wr), 32'h1);
    check("img_done", 32'(load_done), 32'h1);

    wq.delete();
    send_byte(8'h3C, 1'b1, 1);
    repeat (8) @(negedge clk);
    check("extra_no_write", 32'(wq.size()), 32'd0);
    check("extra_done_hold", 32'(load_done), 32'h1);
    check("no_overlap", 32'(overlap), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
